// File: rtl/minterm_sweeper.sv
// Sweeps a 4-input SoP unit through all 16 input vectors, captures its truth
// table and scores it against an expected minterm mask.
module minterm_sweeper #(
    parameter logic [15:0] EXPECTED = 16'hAC3C,
    parameter int          SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [4:0]  err_count,
    output logic        pass
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       launch;
    logic       mismatch;

    // The swept vector is the index itself, so a..d only move when idx does.
    assign {a, b, c, d} = idx;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        // Case inequality so an x/z sample is scored as a mismatch.
        mismatch  = (s !== EXPECTED[idx]);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    launch    = 1'b1;
                end
            end
            ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE: state_nxt = (idx == 4'd15) ? ST_DONE : ST_SETTLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 4'd0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            result    <= 16'h0000;
            err_count <= 5'd0;
        end else if (launch) begin
            idx       <= 4'd0;
            cnt       <= 4'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            result    <= 16'h0000;
            err_count <= 5'd0;
        end else begin
            case (state)
                ST_SETTLE: cnt <= cnt + 4'd1;
                ST_SAMPLE: begin
                    result[idx] <= s;
                    if (mismatch) err_count <= err_count + 5'd1;
                    if (idx == 4'd15) begin
                        // pass must include the final sample's score.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == 5'd0) && !mismatch;
                    end else begin
                        idx <= idx + 4'd1;
                        cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweeper.sv
// Randomised self-checking bench for minterm_sweeper; s is produced by a
// behavioural SoP stand-in and results are scored against a truth-table model.
module tb_minterm_sweeper;

    localparam logic [15:0] EXP = 16'hAC3C;
    localparam int GOLD = 0, ZERO = 1, INV = 2, XAT9 = 3, RND = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start3 = 1'b0;
    int   mode = GOLD;
    logic [15:0] rnd_tab = 16'h0000;
    logic xval;

    logic a1, b1, c1, d1, busy1, done1, pass1, s1;
    logic a3, b3, c3, d3, busy3, done3, pass3, s3;
    logic [15:0] result1, result3;
    logic [4:0]  err1, err3;

    int checks = 0;
    int failures = 0;
    int vecs[$];

    always #5 clk = ~clk;

    function automatic logic sval(input int m, input logic [3:0] i, input logic [15:0] rt, input logic xv);
        logic [15:0] e;
        e = EXP;
        case (m)
            GOLD:    return e[i];
            ZERO:    return 1'b0;
            INV:     return ~e[i];
            XAT9:    return (i == 4'd9) ? xv : e[i];
            default: return rt[i];
        endcase
    endfunction

    function automatic logic [15:0] model_result(input int m);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = sval(m, 4'(i), rnd_tab, xval);
        return r;
    endfunction

    function automatic logic [4:0] model_err(input int m);
        int n;
        logic [15:0] e;
        e = EXP;
        n = 0;
        for (int i = 0; i < 16; i++) if (sval(m, 4'(i), rnd_tab, xval) !== e[i]) n++;
        return 5'(n);
    endfunction

    assign s1 = sval(mode, {a1, b1, c1, d1}, rnd_tab, xval);
    assign s3 = sval(mode, {a3, b3, c3, d3}, rnd_tab, xval);

    minterm_sweeper #(.EXPECTED(EXP), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .s(s1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .result(result1), .err_count(err1), .pass(pass1));

    minterm_sweeper #(.EXPECTED(EXP), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .s(s3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .result(result3), .err_count(err3), .pass(pass3));

    // Leaves us at the first negedge after the accepting edge.
    task automatic pulse(input int which);
        @(negedge clk);
        if (which == 3) start3 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; -1 on timeout.
    // Optionally re-pulses start once when the vector reaches restart_idx.
    task automatic wait_done(input int which, input int restart_idx, output int cyc);
        logic dn;
        int   v;
        bit   re_done;
        re_done = 0;
        cyc = 0;
        vecs.delete();
        forever begin
            dn = (which == 3) ? done3 : done1;
            v  = (which == 3) ? int'({a3, b3, c3, d3}) : int'({a1, b1, c1, d1});
            if (dn) break;
            if (cyc >= 300) begin cyc = -1; break; end
            vecs.push_back(v);
            if (restart_idx >= 0 && v == restart_idx && !re_done) begin
                start = 1'b1;
                re_done = 1;
            end else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a1, b1, c1, d1, busy1, done1, pass1, result1, err1} !== 28'd0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h want=0", {a1, b1, c1, d1, busy1, done1, pass1, result1, err1});
        end
        checks++;
        if ({a3, b3, c3, d3, busy3, done3, pass3, result3, err3} !== 28'd0) begin
            failures++;
            $display("FAIL reset_dut3 got=%h want=0", {a3, b3, c3, d3, busy3, done3, pass3, result3, err3});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_golden();
        int cyc, bad;
        mode = GOLD;
        pulse(1);
        checks++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL golden_busy got busy=%b done=%b want busy=1 done=0", busy1, done1);
        end
        wait_done(1, -1, cyc);
        checks++;
        if (cyc != 32) begin failures++; $display("FAIL golden_latency got=%0d want=32", cyc); end
        bad = (vecs.size() == 32) ? 0 : 1;
        foreach (vecs[k]) if (vecs[k] != k / 2) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL golden_vectors bad=%0d want=0 size=%0d", bad, vecs.size()); end
        checks++;
        if (result1 !== 16'hAC3C || err1 !== 5'd0 || pass1 !== 1'b1 || busy1 !== 1'b0 || {a1, b1, c1, d1} !== 4'hF) begin
            failures++;
            $display("FAIL golden_end got res=%h err=%0d pass=%b busy=%b abcd=%h want AC3C 0 1 0 F",
                     result1, err1, pass1, busy1, {a1, b1, c1, d1});
        end
    endtask

    task automatic test_patterns();
        int cyc;
        int modes[2] = '{ZERO, INV};
        foreach (modes[m]) begin
            mode = modes[m];
            pulse(1);
            wait_done(1, -1, cyc);
            checks++;
            if (cyc != 32 || result1 !== model_result(mode) || err1 !== model_err(mode) || pass1 !== 1'b0) begin
                failures++;
                $display("FAIL pattern_%0d got cyc=%0d res=%h err=%0d pass=%b want 32 %h %0d 0",
                         mode, cyc, result1, err1, pass1, model_result(mode), model_err(mode));
            end
        end
    endtask

    task automatic test_settle3();
        int cyc, bad;
        mode = GOLD;
        pulse(3);
        wait_done(3, -1, cyc);
        checks++;
        if (cyc != 64) begin failures++; $display("FAIL settle3_latency got=%0d want=64", cyc); end
        bad = (vecs.size() == 64) ? 0 : 1;
        foreach (vecs[k]) if (vecs[k] != k / 4) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL settle3_vectors bad=%0d want=0", bad); end
        checks++;
        if (result3 !== 16'hAC3C || err3 !== 5'd0 || pass3 !== 1'b1) begin
            failures++;
            $display("FAIL settle3_end got res=%h err=%0d pass=%b want AC3C 0 1", result3, err3, pass3);
        end
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        mode = GOLD;
        pulse(1);
        n = 0;
        while ({a1, b1, c1, d1} != 4'd5 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin failures++; $display("FAIL midreset_reach got=timeout want=index5"); end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({a1, b1, c1, d1, busy1, done1, pass1, result1, err1} !== 28'd0) begin
            failures++;
            $display("FAIL midreset_async got=%h want=0", {a1, b1, c1, d1, busy1, done1, pass1, result1, err1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1);
        wait_done(1, -1, cyc);
        checks++;
        if (cyc != 32 || result1 !== 16'hAC3C || pass1 !== 1'b1) begin
            failures++;
            $display("FAIL midreset_resweep got cyc=%0d res=%h pass=%b want 32 AC3C 1", cyc, result1, pass1);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        mode = GOLD;
        pulse(1);
        wait_done(1, 7, cyc);
        checks++;
        if (cyc != 32 || result1 !== 16'hAC3C || err1 !== 5'd0) begin
            failures++;
            $display("FAIL busy_start got cyc=%0d res=%h err=%0d want 32 AC3C 0", cyc, result1, err1);
        end
    endtask

    task automatic test_x_and_restart();
        int cyc;
        mode = XAT9;
        pulse(1);
        wait_done(1, -1, cyc);
        checks++;
        if (cyc != 32 || result1 !== model_result(XAT9) || err1 !== model_err(XAT9) || pass1 !== (model_err(XAT9) == 5'd0)) begin
            failures++;
            $display("FAIL xsample got cyc=%0d res=%h err=%0d pass=%b want 32 %h %0d %b", cyc, result1, err1, pass1,
                     model_result(XAT9), model_err(XAT9), model_err(XAT9) == 5'd0);
        end
        mode = GOLD;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || result1 !== 16'h0000 || err1 !== 5'd0 || pass1 !== 1'b0) begin
            failures++;
            $display("FAIL done_restart got done=%b busy=%b res=%h err=%0d pass=%b want 0 1 0000 0 0",
                     done1, busy1, result1, err1, pass1);
        end
        @(negedge clk);
        wait_done(1, -1, cyc);
        checks++;
        if (cyc != 31 || result1 !== 16'hAC3C || pass1 !== 1'b1) begin
            failures++;
            $display("FAIL restart_sweep got cyc=%0d res=%h pass=%b want 31 AC3C 1", cyc, result1, pass1);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int it = 0; it < 6; it++) begin
            rnd_tab = 16'($urandom);
            if (it == 0) rnd_tab = EXP;
            mode = RND;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse(1);
            wait_done(1, -1, cyc);
            checks++;
            if (cyc != 32 || result1 !== rnd_tab || err1 !== model_err(RND) || pass1 !== (rnd_tab == EXP)) begin
                failures++;
                $display("FAIL random_%0d got cyc=%0d res=%h err=%0d pass=%b want 32 %h %0d %b", it, cyc, result1,
                         err1, pass1, rnd_tab, model_err(RND), rnd_tab == EXP);
            end
        end
    endtask

    initial begin
        xval = 1'bx;
        test_reset();
        test_golden();
        test_patterns();
        test_settle3();
        test_reset_mid();
        test_start_ignored();
        test_x_and_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
